// File: rtl/qspi_link_pkg.sv
// qspi_link_pkg
//   Shared definitions for the target end of the 4-lane nibble link:
//   FSM state encoding, synchronizer depth and the default fill byte.
package qspi_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // csb high, lanes released
    ST_HI   = 2'd1,   // waiting for the high nibble of a byte
    ST_LO   = 2'd2    // waiting for the low nibble of a byte
  } qspi_state_e;

  localparam int         SYNC_STAGES  = 2;
  localparam logic [7:0] DEFAULT_FILL = 8'hFF;

endpackage

// File: rtl/qspi_target_port_if.sv
// qspi_target_port_if
//   Bundles the link pins, the RX/TX FIFO handshakes and the frame/error
//   status of qspi_target_port.
//   master : environment side (drives link pins, pops RX, pushes TX)
//   slave  : qspi_target_port itself
interface qspi_target_port_if;
  logic       qspi_csb;
  logic       qspi_sck;
  logic [3:0] qspi_io_in;
  logic [3:0] qspi_io_out;
  logic [3:0] qspi_io_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_active;
  logic       frame_done;
  logic [3:0] frame_bytes;
  logic       err_rx_overflow;
  logic       err_tx_underflow;
  logic       err_partial;
  logic       err_clear;

  modport master (
    output qspi_csb, qspi_sck, qspi_io_in, rx_ready, tx_data, tx_valid, err_clear,
    input  qspi_io_out, qspi_io_oe, rx_data, rx_valid, tx_ready,
           frame_active, frame_done, frame_bytes,
           err_rx_overflow, err_tx_underflow, err_partial
  );

  modport slave (
    input  qspi_csb, qspi_sck, qspi_io_in, rx_ready, tx_data, tx_valid, err_clear,
    output qspi_io_out, qspi_io_oe, rx_data, rx_valid, tx_ready,
           frame_active, frame_done, frame_bytes,
           err_rx_overflow, err_tx_underflow, err_partial
  );
endinterface

// File: rtl/qspi_target_port_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with register storage. Pointers carry one extra
//   wrap bit so full/empty are unambiguous. A push into a full FIFO is
//   accepted when a pop happens in the same cycle.
//   i_push/i_wdata : write request      o_full  : no free entry
//   i_pop          : read request       o_empty : no valid entry
//   o_rdata        : entry at the head (0 after reset)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW:0]                 r_wptr, r_rptr;
  logic                        w_do_push, w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // when full, the slot being written is the one being popped this cycle
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) r_rptr <= r_rptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/qspi_target_port.sv
// qspi_target_port
//   Target end of the 4-lane nibble link. Link pins are synchronized into
//   clk, sck rises (qualified by csb low) clock nibbles in high-first, and
//   each complete byte is pushed into the RX FIFO. For every byte one
//   response byte is popped from the TX FIFO (FILL_BYTE when empty) and
//   presented on the return lanes, high nibble then low nibble.
//   clk, reset : system clock, async active-high reset
//   bus        : link pins, RX/TX FIFO handshakes, frame status, sticky errors
module qspi_target_port
  import qspi_link_pkg::*;
#(
  parameter int         RX_DEPTH  = 8,
  parameter int         TX_DEPTH  = 8,
  parameter logic [7:0] FILL_BYTE = DEFAULT_FILL
) (
  input  logic              clk,
  input  logic              reset,
  qspi_target_port_if.slave bus
);
  // ---- synchronizers: shift registers, oldest stage is the synced value
  logic [SYNC_STAGES-1:0]      r_csb_sync, r_sck_sync;
  logic [SYNC_STAGES-1:0][3:0] r_io_sync;
  logic                        r_csb_d, r_sck_d;
  logic                        w_csb, w_sck;
  logic [3:0]                  w_io;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csb_sync <= '1;
      r_sck_sync <= '0;
      r_io_sync  <= '0;
      r_csb_d    <= 1'b1;
      r_sck_d    <= 1'b0;
    end else begin
      r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], bus.qspi_csb};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.qspi_sck};
      r_io_sync  <= {r_io_sync[SYNC_STAGES-2:0], bus.qspi_io_in};
      r_csb_d    <= w_csb;
      r_sck_d    <= w_sck;
    end
  end

  assign w_csb = r_csb_sync[SYNC_STAGES-1];
  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_io  = r_io_sync[SYNC_STAGES-1];

  logic w_sck_rise, w_csb_rise, w_csb_fall;
  // a csb rise in the same cycle masks the sck rise through ~w_csb
  assign w_sck_rise = w_sck & ~r_sck_d & ~w_csb;
  assign w_csb_rise = w_csb & ~r_csb_d;
  assign w_csb_fall = ~w_csb & r_csb_d;

  // ---- FSM
  qspi_state_e r_state, w_nxt;
  logic        w_start, w_take_hi, w_take_lo, w_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_start   = 1'b0;
    w_take_hi = 1'b0;
    w_take_lo = 1'b0;
    w_end     = 1'b0;
    if (w_csb_rise) begin
      w_end = 1'b1;
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_csb_fall) begin w_start   = 1'b1; w_nxt = ST_HI; end
        ST_HI:   if (w_sck_rise) begin w_take_hi = 1'b1; w_nxt = ST_LO; end
        ST_LO:   if (w_sck_rise) begin w_take_lo = 1'b1; w_nxt = ST_HI; end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- FIFOs
  logic [7:0] w_rx_rdata, w_tx_rdata;
  logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_rx_pop;
  logic [3:0] r_nib_hi;

  assign w_rx_pop = bus.rx_ready & ~w_rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_take_lo),
    .i_wdata ({r_nib_hi, w_io}),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_rdata),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.tx_valid),
    .i_wdata (bus.tx_data),
    .i_pop   (w_take_hi),
    .o_rdata (w_tx_rdata),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  assign bus.rx_data  = w_rx_rdata;
  assign bus.rx_valid = ~w_rx_empty;
  assign bus.tx_ready = ~w_tx_full;

  // ---- datapath: response lanes trail the capture by one cycle
  logic [7:0] r_resp;
  logic       r_ld_hi, r_ld_lo;
  logic [3:0] r_io_out, r_io_oe, r_bytes;
  logic       r_done, r_ovf, r_udf, r_part;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nib_hi <= '0;
      r_resp   <= '0;
      r_ld_hi  <= 1'b0;
      r_ld_lo  <= 1'b0;
      r_io_out <= '0;
      r_io_oe  <= '0;
      r_bytes  <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_part   <= 1'b0;
    end else begin
      r_ld_hi <= w_take_hi;
      r_ld_lo <= w_take_lo;
      r_done  <= w_end;

      if (w_take_hi) begin
        r_nib_hi <= w_io;
        r_resp   <= w_tx_empty ? FILL_BYTE : w_tx_rdata;
      end

      if (w_end) begin
        r_io_out <= '0;
        r_io_oe  <= '0;
      end else begin
        if (w_start) r_io_oe  <= 4'hF;
        if (r_ld_hi)      r_io_out <= r_resp[7:4];
        else if (r_ld_lo) r_io_out <= r_resp[3:0];
      end

      if (w_start)                           r_bytes <= '0;
      else if (w_take_lo && r_bytes != 4'hF) r_bytes <= r_bytes + 4'd1;

      if (bus.err_clear) begin
        r_ovf  <= 1'b0;
        r_udf  <= 1'b0;
        r_part <= 1'b0;
      end else begin
        if (w_take_hi && w_tx_empty)            r_udf  <= 1'b1;
        if (w_take_lo && w_rx_full && !w_rx_pop) r_ovf <= 1'b1;
        if (w_end && r_state == ST_LO)          r_part <= 1'b1;
      end
    end
  end

  assign bus.qspi_io_out      = r_io_out;
  assign bus.qspi_io_oe       = r_io_oe;
  assign bus.frame_active     = ~w_csb;
  assign bus.frame_done       = r_done;
  assign bus.frame_bytes      = r_bytes;
  assign bus.err_rx_overflow  = r_ovf;
  assign bus.err_tx_underflow = r_udf;
  assign bus.err_partial      = r_part;
endmodule

// File: tb/tb_qspi_target_port.sv
// Directed bench for qspi_target_port: drives the link pins like the
// bridge does and checks RX data, return lanes, frame status and errors.
module tb_qspi_target_port;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qspi_target_port_if bus();

  qspi_target_port #(.RX_DEPTH(8), .TX_DEPTH(8), .FILL_BYTE(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  always @(negedge clk) if (bus.frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nibble(input logic [3:0] n, input int half, output logic [3:0] ret);
    bus.qspi_io_in = n;
    cyc(half);
    bus.qspi_sck = 1'b1;
    cyc(half);
    ret = bus.qspi_io_out;   // initiator samples return lanes on sck fall
    bus.qspi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half, output logic [7:0] ret);
    logic [3:0] h, l;
    send_nibble(b[7:4], half, h);
    send_nibble(b[3:0], half, l);
    ret = {h, l};
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop_rx(output logic [7:0] d);
    d = bus.rx_data;
    bus.rx_ready = 1'b1;
    cyc(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.err_clear = 1'b1;
    cyc(1);
    bus.err_clear = 1'b0;
  endtask

  initial begin
    logic [7:0] r, d;
    logic [3:0] n;
    int done0;
    reset = 1'b1;
    bus.qspi_csb = 1'b1; bus.qspi_sck = 1'b0; bus.qspi_io_in = 4'h0;
    bus.rx_ready = 1'b0; bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.err_clear = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // reset state
    chk("rst_io_out", bus.qspi_io_out, 4'h0);
    chk("rst_io_oe", bus.qspi_io_oe, 4'h0);
    chk("rst_rx", {bus.rx_valid, bus.rx_data}, 9'h000);
    chk("rst_tx_ready", bus.tx_ready, 1'b1);
    chk("rst_frame", {bus.frame_active, bus.frame_done, bus.frame_bytes}, 6'h00);
    chk("rst_errs", {bus.err_rx_overflow, bus.err_tx_underflow, bus.err_partial}, 3'b000);

    // 1: one byte A3 at full half-period, response 5A
    push_tx(8'h5A);
    bus.qspi_csb = 1'b0;
    cyc(521);
    chk("t1_active", {bus.frame_active, bus.qspi_io_oe}, 5'h1F);
    send_byte(8'hA3, 521, r);
    chk("t1_resp", r, 8'h5A);
    cyc(521);
    bus.qspi_csb = 1'b1;
    cyc(8);
    chk("t1_rx", {bus.rx_valid, bus.rx_data}, 9'h1A3);
    chk("t1_bytes", bus.frame_bytes, 4'd1);
    chk("t1_done", done_cnt, 1);
    chk("t1_oe_off", bus.qspi_io_oe, 4'h0);
    chk("t1_udf", bus.err_tx_underflow, 1'b0);
    pop_rx(d);

    // 2: three bytes with TX empty -> FF responses, underflow
    bus.qspi_csb = 1'b0;
    cyc(8);
    for (int i = 1; i <= 3; i++) begin
      send_byte(i[7:0], 8, r);
      chk("t2_resp", r, 8'hFF);
    end
    cyc(8);
    bus.qspi_csb = 1'b1;
    cyc(8);
    chk("t2_bytes", bus.frame_bytes, 4'd3);
    chk("t2_udf", bus.err_tx_underflow, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      chk("t2_rx_valid", bus.rx_valid, 1'b1);
      pop_rx(d);
      chk("t2_rx_data", d, i[7:0]);
    end
    chk("t2_rx_empty", bus.rx_valid, 1'b0);

    // 3: ten bytes, RX never drained -> keep first 8, overflow
    bus.qspi_csb = 1'b0;
    cyc(8);
    for (int i = 0; i < 10; i++) send_byte(i[7:0], 8, r);
    cyc(8);
    bus.qspi_csb = 1'b1;
    cyc(8);
    chk("t3_bytes", bus.frame_bytes, 4'd10);
    chk("t3_ovf", bus.err_rx_overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pop_rx(d);
      chk("t3_rx_data", d, i[7:0]);
    end
    chk("t3_rx_empty", bus.rx_valid, 1'b0);
    pulse_clear();
    chk("t3_clear", {bus.err_rx_overflow, bus.err_tx_underflow, bus.err_partial}, 3'b000);

    // 4: csb rises after one nibble
    done0 = done_cnt;
    bus.qspi_csb = 1'b0;
    cyc(8);
    send_nibble(4'hC, 8, n);
    cyc(8);
    chk("t4_oe_on", bus.qspi_io_oe, 4'hF);
    bus.qspi_csb = 1'b1;
    cyc(3);
    chk("t4_oe_off", {bus.qspi_io_oe, bus.qspi_io_out}, 8'h00);
    cyc(4);
    chk("t4_partial", bus.err_partial, 1'b1);
    chk("t4_no_push", bus.rx_valid, 1'b0);
    chk("t4_bytes", bus.frame_bytes, 4'd0);
    chk("t4_done", done_cnt - done0, 1);

    // 5: sck toggles with csb high are ignored
    pulse_clear();
    done0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.qspi_io_in = 4'h9;
      bus.qspi_sck = 1'b1; cyc(8);
      bus.qspi_sck = 1'b0; cyc(8);
    end
    chk("t5_no_push", bus.rx_valid, 1'b0);
    chk("t5_oe", bus.qspi_io_oe, 4'h0);
    chk("t5_idle", {bus.frame_active, bus.err_partial}, 2'b00);
    chk("t5_no_done", done_cnt - done0, 0);

    // fill TX, then reset mid-byte of a frame
    for (int i = 0; i < 8; i++) push_tx(8'h10 + i[7:0]);
    chk("t5_tx_full", bus.tx_ready, 1'b0);
    bus.qspi_csb = 1'b0;
    cyc(8);
    send_byte(8'h77, 8, r);
    chk("t5_resp", r, 8'h10);
    send_nibble(4'h3, 8, n);
    cyc(2);
    chk("t5_pre_rst", {bus.rx_valid, bus.qspi_io_oe}, 5'h1F);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_lanes", {bus.qspi_io_oe, bus.qspi_io_out}, 8'h00);
    chk("t5_rst_rx", {bus.rx_valid, bus.rx_data}, 9'h000);
    chk("t5_rst_tx", bus.tx_ready, 1'b1);
    chk("t5_rst_frame", {bus.frame_active, bus.frame_done, bus.frame_bytes}, 6'h00);
    chk("t5_rst_errs", {bus.err_rx_overflow, bus.err_tx_underflow, bus.err_partial}, 3'b000);
    bus.qspi_csb = 1'b1;
    bus.qspi_sck = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(4);

    // FIFOs were emptied: next byte lands alone, response is fill
    bus.qspi_csb = 1'b0;
    cyc(8);
    send_byte(8'h42, 8, r);
    cyc(8);
    bus.qspi_csb = 1'b1;
    cyc(8);
    chk("t5_post_resp", r, 8'hFF);
    chk("t5_post_rx", {bus.rx_valid, bus.rx_data}, 9'h142);
    chk("t5_post_udf", bus.err_tx_underflow, 1'b1);
    pop_rx(d);
    chk("t5_post_empty", bus.rx_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
